reg_list_encoder: RTL and testbench
===================================

Name: reg_list_encoder

Overview:
Sequential priority encoder for the ARM LDM/STM datapath. It latches a 16-bit register-list mask and emits one 4-bit register number per accepted transfer, lowest register first. Each number comes with its word offset and a last-transfer flag. It drives the register-file port select (the 4-bit number the register-file decoders consume) and the address adder during multi-register transfers.

Parameters:
- LIST_W, 16, register-list width; fixed at 16 for ARM (one bit per r0..r15)
- NUM_W, 4, register-number width, log2(LIST_W)

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- START  input  1  load REG_LIST and begin a sequence; honoured only in IDLE
- REG_LIST  input  16  bit i set = transfer register ri
- ADVANCE  input  1  consumer accepted current register; honoured only when VALID=1
- ABORT  input  1  cancel the current sequence (data abort)
- reg_num  output  4  current register number (lowest set bit of remaining mask)
- offset  output  6  word byte offset of current transfer = index*4 (0..60)
- COUNT  output  5  popcount of latched list (0..16)
- VALID  output  1  reg_num/offset meaningful
- LAST  output  1  current register is the final one (VALID && one bit remaining)
- BUSY  output  1  state != IDLE
- DONE  output  1  one-cycle pulse after the final ADVANCE or for an empty list

Behaviour:
- Reset (async, reset_n=0): state=IDLE, remaining=0, index=0, COUNT=0. reg_num=0, offset=0, VALID=0, LAST=0, BUSY=0, DONE=0.
- State machine: IDLE, RUN, FIN.
- IDLE: START=1 at edge -> remaining<=REG_LIST, COUNT<=popcount(REG_LIST), index<=0. Next state is RUN if REG_LIST!=0, else FIN.
- RUN: VALID=1. reg_num = index of the lowest set bit of remaining, decoded from registered state (no input-to-output path). offset={index,2'b00}. LAST=1 when remaining has exactly one bit set.
- RUN, ADVANCE=1 at edge: clear bit reg_num in remaining, index<=index+1. If LAST=1, next state is FIN.
- RUN, ADVANCE=0: hold all outputs stable. Unlimited stall.
- FIN: DONE=1 for exactly one cycle, VALID=0, then IDLE. remaining=0. COUNT and index hold until the next START.
- Latency: START sampled at edge k -> VALID=1 after edge k. ADVANCE at edge m -> next reg_num after edge m. Back-to-back ADVANCE gives one register per cycle.
- Total for an N-register list: N cycles minimum in RUN, then 1 cycle in FIN.
- ABORT=1 at edge, any state: state<=IDLE, remaining<=0, VALID=0, no DONE pulse. ABORT has priority over ADVANCE and START.
- START while BUSY: ignored; the latched list is unaffected. REG_LIST changes after START have no effect.
- ADVANCE while VALID=0: ignored.
- Empty list: COUNT=0, no VALID cycle, DONE pulses the cycle after START.
- Full list 0xFFFF: reg_num 0..15 in order, offsets 0..60, COUNT=16 (needs all 5 bits). index must not wrap before FIN.
- Reset asserted mid-sequence: immediate return to reset values, no DONE.
- BUSY=1 in RUN and FIN.

Test Plan:
- Reset, then REG_LIST=16'h0000 with START -> next cycle DONE=1, VALID=0, COUNT=0; the cycle after that BUSY=0.
- REG_LIST=16'h8011, START, ADVANCE held 1 -> reg_num/offset/LAST sequence is 0/0/0, 4/4/0, 15/8/1. COUNT=3. DONE the cycle after the third ADVANCE.
- REG_LIST=16'hFFFF, ADVANCE every cycle -> reg_num 0..15, offset 0..60 step 4, COUNT=16, LAST only on r15, exactly 17 cycles from START to DONE.
- REG_LIST=16'h0A00, ADVANCE low 5 cycles then high -> reg_num=9 stable through the stall, then 11 with LAST=1. A START pulsed during the stall is ignored.
- REG_LIST=16'h00F0, after first ADVANCE assert ABORT together with ADVANCE -> VALID=0, BUSY=0 next cycle, no DONE. A fresh START of 16'h0002 then yields reg_num=1, LAST=1.
- Sequence running on 16'h0300, reset_n pulsed low between clock edges -> all outputs 0 immediately without a clock edge. No DONE after release.

Source files
------------

// File: rtl/reg_list_encoder.sv
// reg_list_encoder: sequential lowest-first register-number encoder for LDM/STM transfers.
// Emits one register number, word offset and last flag per accepted ADVANCE.
module reg_list_encoder #(
    parameter int LIST_W = 16,
    parameter int NUM_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              START,
    input  logic [LIST_W-1:0] REG_LIST,
    input  logic              ADVANCE,
    input  logic              ABORT,
    output logic [NUM_W-1:0]  reg_num,
    output logic [NUM_W+1:0]  offset,
    output logic [NUM_W:0]    COUNT,
    output logic              VALID,
    output logic              LAST,
    output logic              BUSY,
    output logic              DONE
);
    localparam int CW = NUM_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state, state_nx;
    logic [LIST_W-1:0] remaining;
    logic [NUM_W:0]    index;
    logic [NUM_W-1:0]  lowest;
    logic              single;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (ABORT) state_nx = IDLE;
        else if (state == IDLE) state_nx = START ? ((REG_LIST != '0) ? RUN : FIN) : IDLE;
        else if (state == RUN) state_nx = (ADVANCE && single) ? FIN : RUN;
        else state_nx = IDLE;
    end

    // index is one bit wider than a register number so a full list reaches 16 without wrapping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= '0;
            index     <= '0;
            COUNT     <= '0;
        end else if (ABORT) begin
            remaining <= '0;
        end else if (state == IDLE && START) begin
            remaining <= REG_LIST;
            index     <= '0;
            COUNT     <= CW'($countones(REG_LIST));
        end else if (state == RUN && ADVANCE) begin
            remaining <= remaining & (remaining - LIST_W'(1));
            index     <= index + CW'(1);
        end
    end

    always_comb begin
        lowest = '0;
        for (int i = LIST_W - 1; i >= 0; i--)
            if (remaining[i]) lowest = NUM_W'(i);
        single = (remaining != '0) && ((remaining & (remaining - LIST_W'(1))) == '0);
    end

    always_comb begin
        VALID   = state == RUN;
        LAST    = VALID && single;
        BUSY    = state != IDLE;
        DONE    = state == FIN;
        reg_num = VALID ? lowest : '0;
        offset  = VALID ? {index[NUM_W-1:0], 2'b00} : '0;
    end
endmodule

// File: tb/tb_reg_list_encoder.sv
// tb_reg_list_encoder: directed and randomized checks against a queue-based transfer model.
module tb_reg_list_encoder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        START, ADVANCE, ABORT;
    logic [15:0] REG_LIST;
    logic [3:0]  reg_num;
    logic [5:0]  offset;
    logic [4:0]  COUNT;
    logic        VALID, LAST, BUSY, DONE;

    int checks = 0;
    int errors = 0;

    int q[$];
    bit fin = 0;
    int cnt = 0;
    int idx = 0;

    reg_list_encoder dut (
        .clk(clk), .reset_n(reset_n), .START(START), .REG_LIST(REG_LIST),
        .ADVANCE(ADVANCE), .ABORT(ABORT), .reg_num(reg_num), .offset(offset),
        .COUNT(COUNT), .VALID(VALID), .LAST(LAST), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("valid", VALID, int'(q.size() > 0));
        chk("busy", BUSY, int'(q.size() > 0 || fin));
        chk("done", DONE, int'(fin));
        chk("count", COUNT, cnt);
        chk("last", LAST, int'(q.size() == 1));
        if (q.size() > 0) begin
            chk("reg_num", reg_num, q[0]);
            chk("offset", offset, idx * 4);
        end
    endtask

    task automatic model_update(input bit s, input logic [15:0] l, input bit a, input bit ab);
        if (ab) begin
            q.delete();
            fin = 0;
        end else if (fin) begin
            fin = 0;
        end else if (q.size() > 0) begin
            if (a) begin
                void'(q.pop_front());
                idx++;
                if (q.size() == 0) fin = 1;
            end
        end else if (s) begin
            cnt = 0;
            for (int i = 0; i < 16; i++)
                if (l[i]) begin
                    q.push_back(i);
                    cnt++;
                end
            idx = 0;
            if (q.size() == 0) fin = 1;
        end
    endtask

    task automatic step(input bit s, input logic [15:0] l, input bit a, input bit ab);
        @(negedge clk);
        check_outputs();
        START = s; REG_LIST = l; ADVANCE = a; ABORT = ab;
        @(posedge clk);
        model_update(s, l, a, ab);
    endtask

    initial begin
        logic [15:0] l;
        reset_n = 1'b0; START = 0; ADVANCE = 0; ABORT = 0; REG_LIST = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_reg_num", reg_num, 0);
        chk("rst_offset", offset, 0);
        check_outputs();
        reset_n = 1'b1;

        step(1, 16'h0000, 0, 0);
        step(0, 16'h0000, 0, 0);
        step(0, 16'h0000, 0, 0);

        step(1, 16'h8011, 1, 0);
        repeat (5) step(0, 16'h0000, 1, 0);

        step(1, 16'hFFFF, 1, 0);
        repeat (19) step(0, 16'h0000, 1, 0);

        step(1, 16'h0A00, 0, 0);
        step(0, 16'h0000, 0, 0);
        step(1, 16'hFFFF, 0, 0);
        repeat (3) step(0, 16'h0000, 0, 0);
        repeat (4) step(0, 16'h0000, 1, 0);

        step(1, 16'h00F0, 0, 0);
        step(0, 16'h0000, 1, 0);
        step(0, 16'h0000, 1, 1);
        step(0, 16'h0000, 0, 0);
        step(1, 16'h0002, 0, 0);
        step(0, 16'h0000, 0, 0);
        repeat (3) step(0, 16'h0000, 1, 0);

        step(1, 16'h0300, 0, 0);
        step(0, 16'h0000, 1, 0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        q.delete(); fin = 0; cnt = 0; idx = 0;
        chk("arst_reg_num", reg_num, 0);
        chk("arst_offset", offset, 0);
        check_outputs();
        #1 reset_n = 1'b1;
        START = 0; ADVANCE = 1; ABORT = 0;
        repeat (3) step(0, 16'h0000, 1, 0);

        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 5))
                0:       l = 16'h0000;
                1:       l = 16'hFFFF;
                default: l = 16'($urandom);
            endcase
            step($urandom_range(0, 3) == 0, l, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
        end
        step(0, 16'h0000, 0, 1);
        @(negedge clk);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
